jtpopeye_scan2x: RTL and testbench

JTPOPEYE_SCAN2X -- requirements
Module: jtpopeye_scan2x

---
 rtl/jtpopeye_pkg.sv | 23 ++
 rtl/jtpopeye_scan2x_lbuf.sv | 30 +++
 rtl/jtpopeye_scan2x.sv | 181 ++++++++++++++++++
 tb/tb_jtpopeye_scan2x.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye scan doubler: pixel word layout and defaults.
package jtpopeye_pkg;

  localparam int unsigned AW_DEF = 9;
  localparam int unsigned PXL_W  = 9;

  // Stored pixel word: HB in bit 8, then R[7:5], G[4:2], B[1:0]
  typedef struct packed {
    logic       hb;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pxl_t;

  // Control bits that travel alongside the buffer read
  typedef struct packed {
    logic hs;
    logic vs;
    logic vb;
    logic valid;
  } ctl_t;

endpackage

// File: rtl/jtpopeye_scan2x_lbuf.sv
// Two-bank line buffer: simple dual-port RAM, one write port, one registered read port.
// The address MSB selects the bank.
module jtpopeye_scan2x_lbuf
  import jtpopeye_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW:0] waddr,
  input  pxl_t        wdata,
  input  logic [AW:0] raddr,
  output pxl_t        rdata
);

  pxl_t mem [0:(2**(AW+1))-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, one clk latency
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/jtpopeye_scan2x.sv
// Popeye scan doubler: stores each native line in one bank while the previous
// line is played back twice from the other bank at the doubled pixel rate.
module jtpopeye_scan2x
  import jtpopeye_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned HS_LEN = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       pxl2_cen,
  input  logic       en,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [1:0] blue,
  input  logic       HB,
  input  logic       VB,
  input  logic       HS,
  input  logic       VS,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       vga_hb,
  output logic       vga_vb,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam logic [AW-1:0] CNT_MAX = '1;

  pxl_t          pxl_in;
  pxl_t          rdata;
  pxl_t          wdata_q;
  ctl_t          ctl_rd;
  ctl_t          ctl_s1;
  logic          hs_l;
  logic          hsr;
  logic          sat;
  logic          we_q;
  logic [AW:0]   waddr_q;
  logic [AW:0]   raddr;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] line_len;
  logic          wbank;
  logic          lvs;
  logic          lvb;
  logic          seen;
  logic          valid;
  logic          dbl;

  // Input word, HS edge detect, write saturation and read address/control
  always_comb begin
    pxl_in       = '{hb: HB, r: red, g: green, b: blue};
    hsr          = pxl_cen & HS & ~hs_l;
    sat          = (wr_cnt == CNT_MAX);
    raddr        = {~wbank, rd_cnt};
    ctl_rd       = '0;
    ctl_rd.hs    = (32'(rd_cnt) < HS_LEN);
    ctl_rd.vs    = lvs;
    ctl_rd.vb    = lvb;
    ctl_rd.valid = valid;
  end

  // HS sampled at the native pixel rate for edge detection
  always_ff @(posedge clk) begin
    if (pxl_cen) begin
      hs_l <= HS;
    end
  end

  // The HSr pixel is pixel 0 of the new line: it goes to address 0 of the new
  // bank and counting resumes at 1. Writes are registered so that this pixel
  // lands after the bank swap, when reads have already moved to the other bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= pxl_cen & (hsr | ~sat);
      waddr_q <= hsr ? {~wbank, {AW{1'b0}}} : {wbank, wr_cnt};
      wdata_q <= pxl_in;
    end
  end

  // Write counter, line length capture, bank swap and per-line flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      line_len <= '0;
      wbank    <= 1'b0;
      lvs      <= 1'b0;
      lvb      <= 1'b0;
      seen     <= 1'b0;
      valid    <= 1'b0;
      dbl      <= en;
    end else if (hsr) begin
      line_len <= wr_cnt;
      wr_cnt   <= AW'(1);
      wbank    <= ~wbank;
      lvs      <= VS;
      lvb      <= VB;
      seen     <= 1'b1;
      valid    <= valid | seen;
      dbl      <= en;
    end else if (pxl_cen && !sat) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Read counter: plays the stored line back repeatedly at the doubled rate
  always_ff @(posedge clk) begin
    if (!rst_n || hsr) begin
      rd_cnt <= '0;
    end else if (pxl2_cen) begin
      if (line_len == '0 || rd_cnt == line_len - 1'b1) begin
        rd_cnt <= '0;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Control bits delayed to line up with the buffer read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_s1 <= '0;
    end else begin
      ctl_s1 <= ctl_rd;
    end
  end

  jtpopeye_scan2x_lbuf #(
    .AW (AW)
  ) u_lbuf (
    .clk   (clk),
    .we    (we_q),
    .waddr (waddr_q),
    .wdata (wdata_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Output registers: doubled video with blanking, or native pass-through
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hb    <= 1'b0;
      vga_vb    <= 1'b0;
      vga_hs    <= 1'b0;
      vga_vs    <= 1'b0;
    end else if (dbl) begin
      vga_hb <= rdata.hb;
      vga_vb <= ctl_s1.vb;
      vga_hs <= ctl_s1.hs;
      vga_vs <= ctl_s1.vs;
      if (rdata.hb || ctl_s1.vb || !ctl_s1.valid) begin
        vga_red   <= '0;
        vga_green <= '0;
        vga_blue  <= '0;
      end else begin
        vga_red   <= rdata.r;
        vga_green <= rdata.g;
        vga_blue  <= rdata.b;
      end
    end else if (pxl_cen) begin
      vga_red   <= red;
      vga_green <= green;
      vga_blue  <= blue;
      vga_hb    <= HB;
      vga_vb    <= VB;
      vga_hs    <= HS;
      vga_vs    <= VS;
    end
  end

endmodule

// File: tb/tb_jtpopeye_scan2x.sv
// Bench for jtpopeye_scan2x: random and ramp lines against a line-level reference model.
module tb_jtpopeye_scan2x;

  localparam int unsigned AW      = 9;
  localparam int unsigned HS_LEN  = 48;
  localparam int unsigned MAX_LEN = (2**AW) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       pxl2_cen = 1'b0;
  logic       en = 1'b1;
  logic [2:0] red = '0;
  logic [2:0] green = '0;
  logic [1:0] blue = '0;
  logic       HB = 1'b0;
  logic       VB = 1'b0;
  logic       HS = 1'b0;
  logic       VS = 1'b0;
  logic [2:0] vga_red;
  logic [2:0] vga_green;
  logic [1:0] vga_blue;
  logic       vga_hb;
  logic       vga_vb;
  logic       vga_hs;
  logic       vga_vs;

  int unsigned checks = 0;
  int unsigned errors = 0;

  jtpopeye_scan2x #(
    .AW     (AW),
    .HS_LEN (HS_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .pxl2_cen  (pxl2_cen),
    .en        (en),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .HB        (HB),
    .VB        (VB),
    .HS        (HS),
    .VS        (VS),
    .vga_red   (vga_red),
    .vga_green (vga_green),
    .vga_blue  (vga_blue),
    .vga_hb    (vga_hb),
    .vga_vb    (vga_vb),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (line level) ----------------
  bit [8:0]    q[$];        // pixels of the line being received
  bit [8:0]    shown[$];    // last completed line
  int unsigned len_m = 0;   // playback length of shown line
  int unsigned j_m = 0;     // doubled ticks since the line started
  int unsigned hcnt = 0;    // HS rising edges since reset
  bit          lvs_m = 0, lvb_m = 0, mode_m = 1, hs_prev = 0;
  bit          rst_prev = 0, started = 0;
  bit [10:0]   rec1_ctl = '0, rec2_ctl = '0, exp_ctl = '0;
  bit          rec1_hb = 0, rec2_hb = 0, exp_hb = 0;
  bit          rec1_kn = 0, rec2_kn = 0, exp_kn = 1;

  task automatic model_step();
    bit          hsr_m;
    bit [8:0]    w;
    bit          known;
    int unsigned a;
    bit [7:0]    col;
    // what the outputs must show after this edge
    if (!rst_n) begin
      exp_ctl = '0; exp_hb = 0; exp_kn = 1;
    end else if (mode_m) begin
      if (rst_prev) begin
        exp_ctl = '0; exp_kn = 0;
      end else begin
        exp_ctl = rec2_ctl; exp_hb = rec2_hb; exp_kn = rec2_kn;
      end
    end else if (pxl_cen) begin
      exp_ctl = {VB, HS, VS, red, green, blue}; exp_hb = HB; exp_kn = 1;
    end
    // line-level state
    if (!rst_n) begin
      q.delete(); shown.delete();
      len_m = 0; j_m = 0; hcnt = 0; lvs_m = 0; lvb_m = 0; mode_m = en;
    end else begin
      hsr_m = pxl_cen && HS && !hs_prev;
      if (hsr_m) begin
        len_m = (q.size() > MAX_LEN) ? MAX_LEN : q.size();
        shown = q;
        q.delete();
        q.push_back({HB, red, green, blue});
        j_m = 0; lvs_m = VS; lvb_m = VB; hcnt++; mode_m = en;
      end else begin
        if (pxl_cen) q.push_back({HB, red, green, blue});
        if (pxl2_cen) j_m++;
      end
    end
    if (pxl_cen) hs_prev = HS;
    // doubled-path view of the state just reached
    a = (len_m == 0) ? 0 : (j_m % len_m);
    if (a < shown.size()) begin
      w = shown[a]; known = 1;
    end else begin
      w = '0; known = 0;
    end
    col = (hcnt >= 2 && known && !w[8] && !lvb_m) ? w[7:0] : 8'h00;
    rec2_ctl = rec1_ctl; rec2_hb = rec1_hb; rec2_kn = rec1_kn;
    rec1_ctl = {lvb_m, (a < HS_LEN), lvs_m, col};
    rec1_hb  = w[8];
    rec1_kn  = known;
    rst_prev = !rst_n;
    started  = 1;
  endtask

  task automatic compare_outputs();
    if (started) begin
      check_eq("vga_out", {21'd0, vga_vb, vga_hs, vga_vs, vga_red, vga_green, vga_blue},
               {21'd0, exp_ctl});
      if (exp_kn) check_eq("vga_hb", {31'd0, vga_hb}, {31'd0, exp_hb});
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) compare_outputs();

  // ---------------- stimulus ----------------
  task automatic idle(input int unsigned npix);
    for (int unsigned p = 0; p < npix; p++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        @(posedge clk); #2;
        pxl_cen  = (c == 0);
        pxl2_cen = (c == 0 || c == 2);
        HS = 1'b0;
      end
    end
  endtask

  task automatic run_line(input int unsigned len, input bit vs_in, input bit vb_in, input bit ramp,
                          input int rst_pix, input int en_pix, input bit en_val);
    logic [7:0] pix;
    for (int unsigned p = 0; p < len; p++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        @(posedge clk); #2;
        if (c == 1 && int'(p) == rst_pix)
          check_eq("rst_mid_zero", {25'd0, vga_hb, vga_vb, vga_hs, vga_vs, vga_red, vga_green, vga_blue}, 32'd0);
        pxl_cen  = (c == 0);
        pxl2_cen = (c == 0 || c == 2);
        if (c == 0) begin
          HS = (p < 30);
          VS = vs_in;
          VB = vb_in;
          if (ramp) begin
            pix = p[7:0];
            HB  = 1'b0;
          end else begin
            pix = 8'($urandom);
            HB  = (p + 40 >= len) || ($urandom_range(0, 15) == 0);
          end
          {red, green, blue} = pix;
          if (int'(p) == en_pix) en = en_val;
          if (int'(p) == rst_pix) rst_n = 1'b0;
        end
        if (c == 3 && int'(p) == rst_pix) rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_eq("rst_zero", {25'd0, vga_hb, vga_vb, vga_hs, vga_vs, vga_red, vga_green, vga_blue}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    // VS high on the first three lines
    for (int i = 0; i < 3; i++) run_line(320, 1, 0, 0, -1, -1, 1);
    // ramp lines
    run_line(320, 0, 0, 1, -1, -1, 1);
    run_line(320, 0, 0, 1, -1, -1, 1);
    run_line(320, 0, 0, 0, -1, -1, 1);
    // over-long line saturates the write counter
    run_line(600, 0, 0, 1, -1, -1, 1);
    run_line(320, 0, 0, 0, -1, -1, 1);
    // switch to pass-through mid-line, then back
    run_line(320, 0, 0, 0, -1, 100, 0);
    run_line(320, 0, 0, 0, -1, -1, 0);
    run_line(320, 0, 0, 1, -1, 200, 1);
    run_line(320, 0, 0, 1, -1, -1, 1);
    run_line(320, 0, 0, 0, -1, -1, 1);
    // vertical blank line
    run_line(320, 0, 1, 0, -1, -1, 1);
    run_line(320, 0, 0, 0, -1, -1, 1);
    // reset mid-line
    run_line(320, 0, 0, 0, 150, -1, 1);
    for (int i = 0; i < 3; i++) run_line(320, 0, 0, 1, -1, -1, 1);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
